// File: rtl/debouncer_pkg.sv
// Shared types and constant helpers for the push-button debouncer.
// Latency: n/a (compile-time only).
// Backpressure: n/a.
//
// Contents:
//   deb_state_t   - debouncer FSM states
//   blank_cycles  - number of blanking cycles from clock rate and blanking time
//   cnt_width     - width of a counter able to hold 0..N
package debouncer_pkg;

    // IDLE          : button released, watching for a press
    // PRESS_BLANK   : press accepted, input ignored while contacts settle
    // HELD          : button pressed, watching for a release
    // RELEASE_BLANK : release accepted, input ignored while contacts settle
    typedef enum logic [1:0] {
        IDLE          = 2'd0,
        PRESS_BLANK   = 2'd1,
        HELD          = 2'd2,
        RELEASE_BLANK = 2'd3
    } deb_state_t;

    // Blanking length in clock cycles: kHz * ms gives cycles directly.
    function automatic int blank_cycles(input int freq_khz, input int bounce_ms);
        return freq_khz * bounce_ms;
    endfunction

    // Counter must represent 0..N; a degenerate N still yields a legal
    // 1-bit vector so elaboration reaches the explicit range check.
    function automatic int cnt_width(input int n);
        if (n < 1) begin
            return 1;
        end
        return $clog2(n + 1);
    endfunction

endpackage : debouncer_pkg

// File: rtl/sync_2ff.sv
// Two-flop synchroniser bringing an asynchronous level into the clk domain.
// Latency: 2 clk edges from d_i to q_o.
// Backpressure: none; free-running level path.
//
// Ports:
//   clk   - destination clock
//   rst_n - asynchronous active-low reset, both flops load RST_VAL
//   d_i   - asynchronous input level
//   q_o   - synchronised level
module sync_2ff #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic s1_q;
    logic s2_q;

    // First stage may go metastable; the second stage gives it a full
    // cycle to resolve before anything downstream looks at it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= RST_VAL;
            s2_q <= RST_VAL;
        end else begin
            s1_q <= d_i;
            s2_q <= s1_q;
        end
    end

    assign q_o = s2_q;

endmodule : sync_2ff

// File: rtl/debouncer.sv
// Push-button conditioner: synchronise raw button, blank bounce after each accepted edge.
// Latency: 3 clk edges from a clean input change to xDeb / pulse (2 sync + 1 output reg).
// Backpressure: none; pulses are single-cycle and must be consumed when asserted.
//
// Ports:
//   clk      - system clock
//   rst_n    - asynchronous active-low reset; all flops clear immediately
//   x        - raw asynchronous button level (rest level = XPOL)
//   xDeb     - debounced level, 1 = pressed regardless of XPOL
//   xDebRise - one-cycle pulse on an accepted press
//   xDebFall - one-cycle pulse on an accepted release
module debouncer
    import debouncer_pkg::*;
#(
    parameter int   FREQ_KHZ  = 50_000,
    parameter int   BOUNCE_MS = 50,
    parameter logic XPOL      = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic x,
    output logic xDeb,
    output logic xDebRise,
    output logic xDebFall
);

    localparam int N  = blank_cycles(FREQ_KHZ, BOUNCE_MS);
    localparam int CW = cnt_width(N);

    // Terminal count of a blanking window: the window spans counts 0..N-1.
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

    if (N < 1) begin : g_bad_blank
        $error("debouncer: FREQ_KHZ*BOUNCE_MS must be at least 1");
    end

    // ------------------------------------------------------------------
    // Input synchroniser. Resetting to the rest level means a released
    // button looks idle straight out of reset and raises no event.
    // ------------------------------------------------------------------
    logic x_sync;

    sync_2ff #(
        .RST_VAL (XPOL)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (x),
        .q_o   (x_sync)
    );

    // Active-high "button pressed" view, independent of pin polarity.
    logic act;
    assign act = (x_sync != XPOL);

    // ------------------------------------------------------------------
    // FSM state, blanking counter and registered outputs.
    // ------------------------------------------------------------------
    deb_state_t    state_q, state_d;
    logic [CW-1:0] cnt_q,   cnt_d;
    logic          deb_q,   deb_d;
    logic          rise_q,  rise_d;
    logic          fall_q,  fall_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            deb_q   <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            deb_q   <= deb_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    // Pulses default low every cycle, so each can only be high for the
    // single cycle following the transition that set it. Rise is only
    // produced leaving IDLE and fall only leaving HELD, so they can
    // never coincide.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        deb_d   = deb_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (act) begin
                    deb_d   = 1'b1;
                    rise_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = PRESS_BLANK;
                end
            end

            // Input is not looked at here: contact bounce is ignored for
            // the whole window. A release that happened meanwhile is
            // picked up on the first HELD cycle.
            PRESS_BLANK: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = HELD;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            HELD: begin
                if (!act) begin
                    deb_d   = 1'b0;
                    fall_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = RELEASE_BLANK;
                end
            end

            RELEASE_BLANK: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            default: begin
                cnt_d   = '0;
                deb_d   = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    assign xDeb     = deb_q;
    assign xDebRise = rise_q;
    assign xDebFall = fall_q;

endmodule : debouncer

// File: tb/tb_debouncer.sv
// Directed bench for debouncer: two instances (rest level 0 and rest level 1),
// FREQ_KHZ=1, BOUNCE_MS=5 so the blanking window is 5 cycles.
// Cycle k means "sampled 1 time unit after the k-th rising edge since x changed".
module tb_debouncer;

    logic clk = 1'b0;
    logic rst_n;
    logic x0, x1;
    logic deb0, rise0, fall0;
    logic deb1, rise1, fall1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    debouncer #(
        .FREQ_KHZ  (1),
        .BOUNCE_MS (5),
        .XPOL      (1'b0)
    ) dut0 (
        .clk      (clk),
        .rst_n    (rst_n),
        .x        (x0),
        .xDeb     (deb0),
        .xDebRise (rise0),
        .xDebFall (fall0)
    );

    debouncer #(
        .FREQ_KHZ  (1),
        .BOUNCE_MS (5),
        .XPOL      (1'b1)
    ) dut1 (
        .clk      (clk),
        .rst_n    (rst_n),
        .x        (x1),
        .xDeb     (deb1),
        .xDebRise (rise1),
        .xDebFall (fall1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        x0    = 1'b0;
        x1    = 1'b1;
        #1;
        checks++;
        if ({deb0, rise0, fall0} !== 3'b000) begin
            errors++;
            $display("FAIL reset_val0 got deb/rise/fall=%b want 000", {deb0, rise0, fall0});
        end
        checks++;
        if ({deb1, rise1, fall1} !== 3'b000) begin
            errors++;
            $display("FAIL reset_val1 got deb/rise/fall=%b want 000", {deb1, rise1, fall1});
        end
        tick();
        tick();
        rst_n = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            tick();
            checks++;
            if ({deb0, rise0, fall0} !== 3'b000) begin
                errors++;
                $display("FAIL reset_quiet0 k=%0d got %b want 000", k, {deb0, rise0, fall0});
            end
            checks++;
            if ({deb1, rise1, fall1} !== 3'b000) begin
                errors++;
                $display("FAIL reset_quiet1 k=%0d got %b want 000", k, {deb1, rise1, fall1});
            end
        end
    endtask

    task automatic test_clean_press();
        logic [2:0] exp;
        x0 = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            tick();
            exp = {(k >= 3 && k < 23), (k == 3), (k == 23)};
            checks++;
            if ({deb0, rise0, fall0} !== exp) begin
                errors++;
                $display("FAIL clean_press k=%0d got deb/rise/fall=%b want %b", k, {deb0, rise0, fall0}, exp);
            end
            if (k == 20) x0 = 1'b0;
        end
    endtask

    task automatic test_bouncy_press();
        logic [2:0] exp;
        int rises;
        rises = 0;
        x0 = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (rise0 === 1'b1) rises++;
            exp = {(k >= 3 && k < 33), (k == 3), (k == 33)};
            checks++;
            if ({deb0, rise0, fall0} !== exp) begin
                errors++;
                $display("FAIL bouncy k=%0d got deb/rise/fall=%b want %b", k, {deb0, rise0, fall0}, exp);
            end
            if (k < 4)       x0 = ~x0;
            else if (k < 30) x0 = 1'b1;
            else             x0 = 1'b0;
        end
        checks++;
        if (rises !== 1) begin
            errors++;
            $display("FAIL bouncy_rise_count got %0d want 1", rises);
        end
    endtask

    task automatic test_release_in_blank();
        logic [2:0] exp;
        x0 = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            tick();
            exp = {(k >= 3 && k < 9), (k == 3), (k == 9)};
            checks++;
            if ({deb0, rise0, fall0} !== exp) begin
                errors++;
                $display("FAIL release_in_blank k=%0d got deb/rise/fall=%b want %b", k, {deb0, rise0, fall0}, exp);
            end
            if (k == 1) x0 = 1'b0;
        end
    endtask

    task automatic test_xpol1();
        logic [2:0] exp;
        x1 = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            tick();
            checks++;
            if ({deb1, rise1, fall1} !== 3'b000) begin
                errors++;
                $display("FAIL xpol1_rest k=%0d got %b want 000", k, {deb1, rise1, fall1});
            end
        end
        x1 = 1'b0;
        for (int k = 1; k <= 22; k++) begin
            tick();
            exp = {(k >= 3 && k < 15), (k == 3), (k == 15)};
            checks++;
            if ({deb1, rise1, fall1} !== exp) begin
                errors++;
                $display("FAIL xpol1_press k=%0d got deb/rise/fall=%b want %b", k, {deb1, rise1, fall1}, exp);
            end
            if (k == 12) x1 = 1'b1;
        end
    endtask

    task automatic test_async_reset();
        logic [2:0] exp;
        x0 = 1'b1;
        for (int k = 1; k <= 4; k++) tick();
        checks++;
        if ({deb0, rise0, fall0} !== 3'b100) begin
            errors++;
            $display("FAIL async_pre got deb/rise/fall=%b want 100", {deb0, rise0, fall0});
        end
        // Assert reset between clock edges: outputs must clear with no edge.
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({deb0, rise0, fall0} !== 3'b000) begin
            errors++;
            $display("FAIL async_clear got deb/rise/fall=%b want 000", {deb0, rise0, fall0});
        end
        tick();
        tick();
        rst_n = 1'b1;
        for (int k = 1; k <= 22; k++) begin
            tick();
            exp = {(k >= 3 && k < 15), (k == 3), (k == 15)};
            checks++;
            if ({deb0, rise0, fall0} !== exp) begin
                errors++;
                $display("FAIL async_rerun k=%0d got deb/rise/fall=%b want %b", k, {deb0, rise0, fall0}, exp);
            end
            if (k == 12) x0 = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bouncy_press();
        test_release_in_blank();
        test_xpol1();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_debouncer

// File: doc/debouncer.md
Name: debouncer

Overview:
- Push-button conditioner for the camera peripheral.
- Synchronises a raw, bouncing button input into the clock domain, then filters out bounce for BOUNCE_MS milliseconds after every accepted edge.
- Delivers a clean active-high "pressed" level plus single-cycle press/release pulses.
- Sits between the board button pin and the capture-enable logic (rec gating) of the camera top.

Parameters:
- FREQ_KHZ, 50_000: clock frequency in kHz.
- BOUNCE_MS, 50: bounce-blanking time in ms.
- XPOL, 1'b0: level of x when the button is released (rest level).

Ports:
- clk, input, 1: system clock (i_wb_clk domain).
- rst_n, input, 1: asynchronous active-low reset.
- x, input, 1: raw asynchronous button input.
- xDeb, output, 1: debounced level; 1 = pressed (x != XPOL).
- xDebRise, output, 1: one-cycle pulse on accepted press.
- xDebFall, output, 1: one-cycle pulse on accepted release.

Behaviour:
- Interface:
  - One clock, clk.
  - Reset rst_n is asynchronous and active-low.
  - All flops clear on rst_n low, independent of clk.
- Constants:
  - N = FREQ_KHZ*BOUNCE_MS blanking cycles.
  - Counter width = $clog2(N+1).
  - N >= 1 is required; elaboration error otherwise.
- Synchroniser:
  - Two flops, x -> s1 -> s2.
  - Both reset to XPOL, so a released button produces no event after reset.
  - act = (s2 != XPOL).
- State machine (registered outputs):
  - IDLE: if act then xDeb<=1, xDebRise<=1, cnt<=0, go to PRESS_BLANK.
  - PRESS_BLANK: input ignored; cnt increments each cycle; when cnt==N-1 go to HELD.
  - HELD: if !act then xDeb<=0, xDebFall<=1, cnt<=0, go to RELEASE_BLANK.
  - RELEASE_BLANK: input ignored; when cnt==N-1 go to IDLE.
- Pulses:
  - xDebRise and xDebFall are high for exactly one cycle.
  - Both are 0 in every other cycle.
  - They are never high in the same cycle.
- Latency: a clean change of x appears on xDeb/pulse 3 clock edges later (2 synchroniser edges + 1 output register edge).
- Blanking:
  - After an accepted edge, any toggling of x during the next N cycles has no effect.
  - If the input level at the end of blanking differs from xDeb, the opposite edge is accepted on the first cycle after blanking ends (the cycle in HELD/IDLE).
- Minimum pulse: a press shorter than the sync delay may be missed; any level stable for >= 3 cycles is always seen.
- Reset values:
  - xDeb=0, xDebRise=0, xDebFall=0.
  - state=IDLE, cnt=0, s1=s2=XPOL.
- Reset mid-operation: returns to IDLE immediately. If the button is still held when rst_n rises, a new press is reported 3 cycles later.
- Polarity: with XPOL=1, x=0 means pressed. xDeb remains active-high in both polarities.

Decomposition:
- Package debouncer_pkg holds the state enum (IDLE, PRESS_BLANK, HELD, RELEASE_BLANK) and a function computing N and the counter width from the parameters.
- One sub-module, sync_2ff: a 2-flop synchroniser with reset value parameter RST_VAL and async active-low reset.
- All other logic lives in debouncer.

Test Plan:
- Reset with x=XPOL=0, FREQ_KHZ=1, BOUNCE_MS=5 (N=5) -> xDeb=0, no pulses for 20 cycles after rst_n rises.
- Clean press: x 0->1 at cycle 0 -> xDebRise=1 only at cycle 3; xDeb=1 from cycle 3; release after 20 cycles -> xDebFall one cycle, 3 cycles after the release.
- Bouncy press: x toggles every cycle for 4 cycles, then stays 1 -> exactly one xDebRise; xDeb stays 1 throughout with no glitch.
- Release inside blanking: x=1 for 1 cycle then 0 -> rise at cycle 3, blanking 5 cycles, then xDebFall on the first cycle after blanking (cycle 9); no further pulses.
- XPOL=1 instance: x held 1 -> xDeb=0; x 1->0 -> xDebRise 3 cycles later.
- Async reset asserted mid PRESS_BLANK with x held 1 -> outputs 0 immediately without a clk edge; after rst_n rises, xDebRise fires 3 cycles later.
